// File: rtl/controle_pc.sv
// Multicycle PC-update sequencer: fetch with memory-latency wait, decode,
// then one branch/jump/exec/exception cycle. Outputs are a Moore decode of state.
module controle_pc #(
    parameter int         MEM_LAT     = 1,
    parameter logic [1:0] EXC_VEC_SEL = 2'b11
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       cond_inv,
    output logic [1:0] pc_source,
    output logic       ir_write,
    output logic       mem_read,
    output logic       epc_write,
    output logic [2:0] estado
);

    localparam logic [2:0] FETCH    = 3'd0;
    localparam logic [2:0] FETCH_WR = 3'd1;
    localparam logic [2:0] DECODE   = 3'd2;
    localparam logic [2:0] BRANCH   = 3'd3;
    localparam logic [2:0] JUMP     = 3'd4;
    localparam logic [2:0] EXEC     = 3'd5;
    localparam logic [2:0] EXCECAO  = 3'd6;

    localparam logic [3:0] CNT_LAST = 4'(MEM_LAT - 1);

    logic [2:0] state, next_state;
    logic [3:0] cnt;
    logic [5:0] op_lat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= FETCH;
            cnt    <= 4'd0;
            op_lat <= 6'd0;
        end else begin
            state <= next_state;
            if (state == FETCH && cnt != CNT_LAST)
                cnt <= cnt + 4'd1;
            else
                cnt <= 4'd0;
            // Branch polarity comes from this copy so later IR changes are ignored
            if (state == DECODE)
                op_lat <= opcode;
        end
    end

    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:    next_state = (cnt == CNT_LAST) ? FETCH_WR : FETCH;
            FETCH_WR: next_state = DECODE;
            DECODE: begin
                case (opcode)
                    6'h04, 6'h05:               next_state = BRANCH;
                    6'h02, 6'h03:               next_state = JUMP;
                    6'h00, 6'h08, 6'h23, 6'h2B: next_state = EXEC;
                    default:                    next_state = EXCECAO;
                endcase
            end
            default:  next_state = FETCH;
        endcase
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        cond_inv      = 1'b0;
        pc_source     = 2'b00;
        ir_write      = 1'b0;
        mem_read      = 1'b0;
        epc_write     = 1'b0;
        case (state)
            FETCH:    mem_read = 1'b1;
            FETCH_WR: begin
                ir_write = 1'b1;
                pc_write = 1'b1;
            end
            BRANCH: begin
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                cond_inv      = (op_lat == 6'h05);
            end
            JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            EXCECAO: begin
                epc_write = 1'b1;
                pc_write  = 1'b1;
                pc_source = EXC_VEC_SEL;
            end
            default: ;
        endcase
    end

    assign estado = state;

endmodule

// File: doc/controle_pc.md
Name: controle_pc

Overview:
- Multicycle sequencer for the PC-update path of the processor.
- Produces the two raw write requests, pc_write (unconditional) and pc_write_cond (conditional), that the downstream OR stage combines with the branch comparator result into the PC register write enable.
- Also drives PC source select, IR write, memory read and EPC write.
- Tracks fetch/decode/execute per instruction, waits out instruction-memory latency, and traps unsupported opcodes.

Parameters:
MEM_LAT, 1, instruction memory read latency in cycles; legal range 1..15.
EXC_VEC_SEL, 2'b11, pc_source code that selects the exception vector.

Ports:
clk  in  1  system clock, rising-edge.
reset  in  1  asynchronous, active-high reset.
opcode  in  6  instruction bits [31:26] from the IR; sampled only in DECODE.
pc_write  out  1  unconditional PC write request to the OR stage.
pc_write_cond  out  1  conditional PC write request (branch) to the OR stage.
cond_inv  out  1  1 = branch taken on not-zero (bne); 0 = taken on zero (beq).
pc_source  out  2  PC mux select: 00 PC+4, 01 ALUOut (branch target), 10 jump address, 11 exception vector.
ir_write  out  1  load IR from memory data.
mem_read  out  1  instruction memory read strobe.
epc_write  out  1  capture current PC into EPC.
estado  out  3  current state code, for debug and bench observation.

Behaviour:
- Clock, reset and state:
  - Single clock.
  - reset is asynchronous and active-high. Asserting it at any time, including mid-fetch or mid-branch, forces state FETCH and wait counter 0 immediately.
  - First active edge after deassert continues from FETCH.
- Outputs are Moore: pure decode of the state register, no input-to-output paths.
- States and codes: FETCH=0, FETCH_WR=1, DECODE=2, BRANCH=3, JUMP=4, EXEC=5, EXCECAO=6. Code 7 is illegal and next-state goes to FETCH.
- FETCH: mem_read=1.
  - 4-bit wait counter increments each cycle.
  - When counter == MEM_LAT-1: go to FETCH_WR and clear counter.
  - FETCH therefore lasts exactly MEM_LAT cycles.
- FETCH_WR (1 cycle): ir_write=1, pc_write=1, pc_source=00 (PC <= PC+4). Next DECODE.
- DECODE (1 cycle): all strobes 0. Samples opcode:
  - 0x04 (beq) or 0x05 (bne) -> BRANCH.
  - 0x02 (j) or 0x03 (jal) -> JUMP.
  - 0x00 (R-type), 0x08 (addi), 0x23 (lw), 0x2B (sw) -> EXEC.
  - Any other value -> EXCECAO.
- BRANCH (1 cycle): pc_write_cond=1, pc_source=01.
  - cond_inv=1 if the latched opcode was 0x05, else 0.
  - Next FETCH.
- JUMP (1 cycle): pc_write=1, pc_source=10. Next FETCH.
- EXEC (1 cycle): no PC strobes. Datapath control is owned elsewhere. Next FETCH.
- EXCECAO (1 cycle): epc_write=1, pc_write=1, pc_source=EXC_VEC_SEL. Next FETCH.
- Opcode latching: opcode is latched into an internal register in DECODE. cond_inv uses the latched copy, so IR changes after DECODE have no effect.
- Defaults: in every state, outputs not listed above are 0. pc_source defaults to 00 and cond_inv defaults to 0.
- Mutual exclusion: pc_write and pc_write_cond are never 1 in the same cycle.
- Reset values: pc_write=0, pc_write_cond=0, cond_inv=0, pc_source=00, ir_write=0, epc_write=0, mem_read=1 (FETCH), estado=0.
- Instruction latency in cycles: MEM_LAT+1 (fetch) +1 (decode) +1 (execute).

Test Plan:
- Reset mid-BRANCH (estado=3), assert reset between edges -> outputs and estado reach reset values within the same cycle without waiting for clk. After release, mem_read=1 for MEM_LAT cycles.
- MEM_LAT=3, opcode=0x00 -> estado sequence 0,0,0,1,2,5,0. pc_write=1 only in cycle 4, with pc_source=00 and ir_write=1.
- MEM_LAT=1, opcode=0x05 -> estado 0,1,2,3. In state 3: pc_write_cond=1, cond_inv=1, pc_source=01, pc_write=0. Repeat with 0x04 -> cond_inv=0.
- opcode=0x02 -> JUMP: pc_write=1, pc_source=10 for exactly one cycle, then estado=0.
- opcode=0x3F -> EXCECAO: epc_write=1, pc_write=1, pc_source=11 for one cycle. Check no other state asserts epc_write.
- Change opcode to 0x04 during BRANCH after DECODE latched 0x05 -> cond_inv stays 1. Assertion runs over the whole run: never (pc_write & pc_write_cond).
